lcd_write_sequencer: RTL

//   Sequences the 9-bit LCD word ROM (Dir_Memoria_LCD -> Data_Memoria_LCD) onto a HD44780-style 8-bit

---
 rtl/lcd_pkg.sv | 51 +++++
 rtl/lcd_delay_timer.sv | 26 ++
 rtl/lcd_write_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write sequencer: FSM and delay encodings, ROM word layout,
// widths and the default HD44780 timing values in 50 MHz clock cycles.
package lcd_pkg;
    localparam int WORD_W  = 9;
    localparam int ADDR_W  = 6;
    localparam int TIMER_W = 20;
    localparam int RS_BIT  = 8;
    localparam logic [7:0] CLR_HOME_MASK = 8'hFC;

    localparam int DEF_LAST_ADDR    = 49;
    localparam int DEF_T_POWERUP    = 750000;
    localparam int DEF_T_SU         = 2;
    localparam int DEF_T_PW         = 12;
    localparam int DEF_T_H          = 2;
    localparam int DEF_T_INIT1      = 205000;
    localparam int DEF_T_INIT2      = 5000;
    localparam int DEF_T_CMD        = 2000;
    localparam int DEF_T_LONG       = 82000;
    localparam int DEF_RESTART_ADDR = 6;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_FETCH,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC,
        ST_NEXT,
        ST_DONE
    } lcd_state_e;

    typedef enum logic [1:0] {
        DLY_INIT1,
        DLY_INIT2,
        DLY_LONG,
        DLY_CMD
    } lcd_delay_e;

    // Clear display and return home (RS=0, DB[7:2]==0) need the long execution time.
    function automatic lcd_delay_e select_delay(input logic [ADDR_W-1:0] addr,
                                                input logic [WORD_W-1:0] word);
        if (addr == ADDR_W'(0))
            return DLY_INIT1;
        else if (addr == ADDR_W'(1))
            return DLY_INIT2;
        else if (!word[RS_BIT] && ((word[7:0] & CLR_HOME_MASK) == 8'h00))
            return DLY_LONG;
        else
            return DLY_CMD;
    endfunction
endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every timed phase of the LCD write sequencer.
// Holds at zero; o_expired marks the final cycle of a phase loaded with (N-1).
module lcd_delay_timer
    import lcd_pkg::*;
#(
    parameter int RESET_VALUE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_value,
    output logic               o_expired
);
    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= TIMER_W'(RESET_VALUE);
        else if (i_load)
            r_count <= i_value;
        else if (r_count != '0)
            r_count <= r_count - TIMER_W'(1);
    end

    assign o_expired = (r_count == '0);
endmodule

// File: rtl/lcd_write_sequencer.sv
// Walks the LCD word ROM once after reset and writes each word onto an HD44780 8-bit bus.
// Optional macro LCD_REFRESH_EN adds Refresh_LCD to replay the ROM from RESTART_ADDR.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int LAST_ADDR    = DEF_LAST_ADDR,
    parameter int T_POWERUP    = DEF_T_POWERUP,
    parameter int T_SU         = DEF_T_SU,
    parameter int T_PW         = DEF_T_PW,
    parameter int T_H          = DEF_T_H,
    parameter int T_INIT1      = DEF_T_INIT1,
    parameter int T_INIT2      = DEF_T_INIT2,
    parameter int T_CMD        = DEF_T_CMD,
    parameter int T_LONG       = DEF_T_LONG,
    parameter int RESTART_ADDR = DEF_RESTART_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] Data_Memoria_LCD,
`ifdef LCD_REFRESH_EN
    input  logic              Refresh_LCD,
`endif
    output logic [ADDR_W-1:0] Dir_Memoria_LCD,
    output logic              LCD_RS,
    output logic              LCD_RW,
    output logic              LCD_E,
    output logic [7:0]        LCD_DB,
    output logic              Busy_LCD,
    output logic              Done_LCD,
    output lcd_state_e        o_dbg_state
);
    lcd_state_e         r_state;
    lcd_state_e         w_next_state;
    lcd_delay_e         r_dly_sel;
    logic [ADDR_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_word;
    logic               r_e;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_val;
    logic [TIMER_W-1:0] w_exec_val;
    logic               w_expired;
    logic               w_addr_inc;
    logic               w_restart;

    lcd_delay_timer #(
        .RESET_VALUE (T_POWERUP - 1)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .o_expired (w_expired)
    );

    // EXEC is loaded two short because the NEXT step is the last cycle of the execution delay.
    always_comb begin
        w_exec_val = TIMER_W'(T_CMD - 2);
        case (r_dly_sel)
            DLY_INIT1: w_exec_val = TIMER_W'(T_INIT1 - 2);
            DLY_INIT2: w_exec_val = TIMER_W'(T_INIT2 - 2);
            DLY_LONG:  w_exec_val = TIMER_W'(T_LONG - 2);
            default:   w_exec_val = TIMER_W'(T_CMD - 2);
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_addr_inc   = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            ST_PWR_WAIT: begin
                if (w_expired)
                    w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                w_next_state = ST_SETUP;
                w_load       = 1'b1;
                w_load_val   = TIMER_W'(T_SU - 1);
            end
            ST_SETUP: begin
                if (w_expired) begin
                    w_next_state = ST_PULSE;
                    w_load       = 1'b1;
                    w_load_val   = TIMER_W'(T_PW - 1);
                end
            end
            ST_PULSE: begin
                if (w_expired) begin
                    w_next_state = ST_HOLD;
                    w_load       = 1'b1;
                    w_load_val   = TIMER_W'(T_H - 1);
                end
            end
            ST_HOLD: begin
                if (w_expired) begin
                    w_next_state = ST_EXEC;
                    w_load       = 1'b1;
                    w_load_val   = w_exec_val;
                end
            end
            ST_EXEC: begin
                if (w_expired)
                    w_next_state = ST_NEXT;
            end
            ST_NEXT: begin
                if (r_addr == ADDR_W'(LAST_ADDR)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_FETCH;
                    w_addr_inc   = 1'b1;
                end
            end
            ST_DONE: begin
`ifdef LCD_REFRESH_EN
                if (Refresh_LCD) begin
                    w_next_state = ST_FETCH;
                    w_restart    = 1'b1;
                end
`endif
            end
            default: w_next_state = ST_PWR_WAIT;
        endcase
    end

    // E is registered from the next state so it is high for exactly the PULSE cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_PWR_WAIT;
            r_addr    <= '0;
            r_word    <= '0;
            r_e       <= 1'b0;
            r_dly_sel <= DLY_CMD;
        end else begin
            r_state <= w_next_state;
            r_e     <= (w_next_state == ST_PULSE);
            if (r_state == ST_FETCH) begin
                r_word    <= Data_Memoria_LCD;
                r_dly_sel <= select_delay(r_addr, Data_Memoria_LCD);
            end
            if (w_addr_inc)
                r_addr <= r_addr + ADDR_W'(1);
            else if (w_restart)
                r_addr <= ADDR_W'(RESTART_ADDR);
        end
    end

    assign Dir_Memoria_LCD = r_addr;
    assign LCD_RS          = r_word[RS_BIT];
    assign LCD_DB          = r_word[7:0];
    assign LCD_RW          = 1'b0;
    assign LCD_E           = r_e;
    assign Busy_LCD        = (r_state != ST_DONE);
    assign Done_LCD        = (r_state == ST_DONE);
    assign o_dbg_state     = r_state;
endmodule
